// File: rtl/max_search_block_16.sv
// max_search_block_16: buffers one FP16 vector, tracks its maximum, then replays the samples with the max alongside.
// Define MAX_NAN_CHECK_EN to add max_nan_o and keep NaN samples out of the maximum.
module max_search_block_16 #(
  parameter int DATA_SIZE      = 16,
  parameter int NUMBER_OF_DATA = 10
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 max_data_valid_i,
  input  logic [DATA_SIZE-1:0] max_data_i,
  output logic                 max_ready_o,
  output logic                 max_data_valid_o,
  output logic [DATA_SIZE-1:0] max_data_o,
  output logic [DATA_SIZE-1:0] max_value_o,
  output logic                 max_last_o
`ifdef MAX_NAN_CHECK_EN
  ,
  output logic                 max_nan_o
`endif
);
  localparam int CW = $clog2(NUMBER_OF_DATA);
  localparam logic [CW-1:0] LAST = CW'(NUMBER_OF_DATA - 1);
  typedef enum logic {COLLECT, REPLAY} state_t;
  state_t state, state_n;
  logic [CW-1:0] count, k;
  logic [DATA_SIZE-1:0] max_q, max_n;
  logic [DATA_SIZE-1:0] mem [NUMBER_OF_DATA];
  logic accept, greater;
`ifdef MAX_NAN_CHECK_EN
  localparam logic [DATA_SIZE-1:0] NEG_INF = DATA_SIZE'(16'hFC00);
  logic is_nan, nan_q;
`endif

  // Sign-magnitude strict greater-than; +0 and -0 are equal.
  function automatic logic fp_gt(input logic [DATA_SIZE-1:0] a, input logic [DATA_SIZE-1:0] b);
    logic [DATA_SIZE-2:0] ma, mb;
    ma = a[DATA_SIZE-2:0];
    mb = b[DATA_SIZE-2:0];
    return (a[DATA_SIZE-1] != b[DATA_SIZE-1]) ? (!a[DATA_SIZE-1] && ((ma | mb) != '0))
         : (a[DATA_SIZE-1] ? (ma < mb) : (ma > mb));
  endfunction

  // Next state, running-max candidate and registered-state-driven outputs.
  always_comb begin
    accept  = (state == COLLECT) && max_data_valid_i;
    greater = fp_gt(max_data_i, max_q);
`ifdef MAX_NAN_CHECK_EN
    is_nan  = (max_data_i[14:10] == 5'h1F) && (max_data_i[9:0] != '0);
    max_n   = (count == '0) ? (is_nan ? NEG_INF : max_data_i) : ((greater && !is_nan) ? max_data_i : max_q);
    max_nan_o = nan_q;
`else
    max_n   = ((count == '0) || greater) ? max_data_i : max_q;
`endif
    state_n = (state == COLLECT) ? ((accept && count == LAST) ? REPLAY : COLLECT)
                                 : ((k == LAST) ? COLLECT : REPLAY);
    max_ready_o      = state == COLLECT;
    max_data_valid_o = state == REPLAY;
    max_data_o       = (state == REPLAY) ? mem[k] : '0;
    max_value_o      = (state == REPLAY) ? max_q : '0;
    max_last_o       = (state == REPLAY) && (k == LAST);
  end

  // State register.
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) state <= COLLECT;
    else         state <= state_n;

  // Collect counter, replay index, running max and NaN flag.
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      count <= '0;
      k     <= '0;
      max_q <= '0;
`ifdef MAX_NAN_CHECK_EN
      nan_q <= 1'b0;
`endif
    end else begin
      if (accept) begin
        count <= (count == LAST) ? '0 : count + 1'b1;
        max_q <= max_n;
`ifdef MAX_NAN_CHECK_EN
        nan_q <= is_nan | (nan_q && (count != '0));
`endif
      end
      if (state == REPLAY) k <= (k == LAST) ? '0 : k + 1'b1;
    end

  // Sample buffer; contents need no reset.
  always_ff @(posedge clock_i)
    if (accept) mem[count] <= max_data_i;
endmodule

// File: tb/tb_max_search_block_16.sv
// tb_max_search_block_16: directed and random vectors checked against a real-valued maximum model.
module tb_max_search_block_16;
  typedef logic [15:0] vec_t [10];
  logic clk = 1'b0;
  logic rst, in_valid;
  logic [15:0] in_data;
  logic ready, out_valid, out_last;
  logic [15:0] out_data, out_max;
`ifdef MAX_NAN_CHECK_EN
  logic nan;
`endif
  int compared = 0;
  int mismatched = 0;
  vec_t v;

  always #5 clk = ~clk;

  max_search_block_16 dut (
    .clock_i(clk),
    .reset_i(rst),
    .max_data_valid_i(in_valid),
    .max_data_i(in_data),
    .max_ready_o(ready),
    .max_data_valid_o(out_valid),
    .max_data_o(out_data),
    .max_value_o(out_max),
    .max_last_o(out_last)
`ifdef MAX_NAN_CHECK_EN
    ,
    .max_nan_o(nan)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic real fp2r(input logic [15:0] h);
    int e, m;
    real r;
    e = int'(h[14:10]);
    m = int'(h[9:0]);
    if (e == 31) r = 1.0e30;
    else if (e == 0) r = real'(m) / 16777216.0;
    else if (e >= 25) r = real'(1024 + m) * real'(1 << (e - 25));
    else r = real'(1024 + m) / real'(1 << (25 - e));
    return h[15] ? -r : r;
  endfunction

  function automatic logic [15:0] ref_max(input vec_t x);
    logic [15:0] m;
    m = x[0];
    for (int i = 1; i < 10; i++) if (fp2r(x[i]) > fp2r(m)) m = x[i];
    return m;
  endfunction

  function automatic logic [15:0] rnd_sample();
    logic [15:0] s;
    s = 16'($urandom);
    if (s[14:10] == 5'h1F) s[9:0] = '0;
    return s;
  endfunction

  task automatic send(input vec_t x, input int gap, input bit hold);
    for (int i = 0; i < 10; i++) begin
      check("ready_collect", 16'(ready), 16'd1);
      check("valid_collect", 16'(out_valid), 16'd0);
      in_valid = 1'b1;
      in_data = x[i];
      step();
      if (i < 9) begin
        in_valid = 1'b0;
        repeat (gap) step();
      end
    end
    if (hold) in_data = 16'h7BFF;
    else in_valid = 1'b0;
  endtask

  task automatic check_replay(input vec_t x, input logic [15:0] mx);
    for (int i = 0; i < 10; i++) begin
      check("replay_valid", 16'(out_valid), 16'd1);
      check("replay_ready", 16'(ready), 16'd0);
      check("replay_data", out_data, x[i]);
      check("replay_max", out_max, mx);
      check("replay_last", 16'(out_last), 16'(i == 9));
      step();
    end
    in_valid = 1'b0;
    check("post_ready", 16'(ready), 16'd1);
    check("post_valid", 16'(out_valid), 16'd0);
    step();
    check("idle_valid", 16'(out_valid), 16'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    repeat (3) step();
    check("rst_ready", 16'(ready), 16'd1);
    check("rst_valid", 16'(out_valid), 16'd0);
    check("rst_data", out_data, 16'h0000);
    check("rst_max", out_max, 16'h0000);
    check("rst_last", 16'(out_last), 16'd0);
`ifdef MAX_NAN_CHECK_EN
    check("rst_nan", 16'(nan), 16'd0);
`endif
    rst = 1'b0;
    step();
    check("rel_ready", 16'(ready), 16'd1);
    check("rel_valid", 16'(out_valid), 16'd0);

    v = '{16'hC283, 16'h4530, 16'hB9D1, 16'h40E9, 16'hB1DE, 16'h3A31, 16'hC1A8, 16'h45F7, 16'hC536, 16'h3CEF};
    send(v, 1, 1'b0);
    check_replay(v, 16'h45F7);

    v = '{16'h8000, 16'hC000, 16'hBC00, 16'h0000, 16'hC400, 16'hBC00, 16'hC200, 16'hC500, 16'hBE00, 16'hC100};
    send(v, 0, 1'b0);
    check_replay(v, 16'h8000);

    for (int i = 0; i < 10; i++) v[i] = rnd_sample();
    send(v, 0, 1'b1);
    check_replay(v, ref_max(v));
    for (int i = 0; i < 10; i++) v[i] = 16'h3000 + 16'(i);
    send(v, 0, 1'b0);
    check_replay(v, 16'h3009);

    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data = rnd_sample();
      step();
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check("arst_ready", 16'(ready), 16'd1);
    step();
    step();
    rst = 1'b0;
    repeat (3) begin
      step();
      check("dropped_valid", 16'(out_valid), 16'd0);
    end
    for (int i = 0; i < 10; i++) v[i] = 16'h3C00;
    v[$urandom_range(0, 9)] = 16'h4000;
    send(v, 2, 1'b0);
    check_replay(v, 16'h4000);

    repeat (6) begin
      for (int i = 0; i < 10; i++) v[i] = rnd_sample();
      send(v, $urandom_range(0, 3), 1'b0);
      check_replay(v, ref_max(v));
    end

`ifdef MAX_NAN_CHECK_EN
    for (int i = 0; i < 10; i++) v[i] = 16'h3800;
    v[2] = 16'h7E00;
    send(v, 1, 1'b0);
    check("nan_set", 16'(nan), 16'd1);
    check_replay(v, 16'h3800);
    check("nan_hold", 16'(nan), 16'd1);
    in_valid = 1'b1;
    in_data = 16'h3C00;
    step();
    in_valid = 1'b0;
    check("nan_clear", 16'(nan), 16'd0);
    for (int i = 0; i < 10; i++) v[i] = 16'h7E01 + 16'(i);
    rst = 1'b1;
    step();
    rst = 1'b0;
    send(v, 0, 1'b0);
    check_replay(v, 16'hFC00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
